mem_stage_unit: RTL and testbench
=================================

# mem_stage_unit

Data-memory access engine for the MEM stage of the pipelined RV32I core. It takes the memory-stage fields of the EX/MEM stage register, runs the load/store handshake with the data cache or port, and stalls the pipeline until the access completes. It produces the aligned, extended load value that feeds the MDR input of the MEM/WB stage register. It is the producer side of the MEM/WB interface; writeback only consumes what this block registers.

## Interface
- Parameters: none.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM-stage instruction valid (not a bubble)
- mem_read_req  in  1  control-word load flag
- mem_write_req  in  1  control-word store flag
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  ALU result (byte address)
- store_data  in  32  rs2 value
- dmem_read  out  1  read request to memory
- dmem_write  out  1  write request to memory
- dmem_address  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_byte_enable  out  4  byte lanes for stores
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- mdr_out  out  32  extended load result, goes to MEM/WB MDR input
- stall  out  1  freeze PC and all stage registers
- misaligned  out  1  current request misaligned; no access issued

## Operation
- FSM states: IDLE, ACCESS, DONE.
- A memory op is req_valid & (mem_read_req | mem_write_req). If both flags are set, the op is a store.
- Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0. funct3 values 011, 110 and 111 are treated as word width.
- IDLE, no memory op: stall=0, stay in IDLE.
- IDLE, misaligned op: misaligned=1 (combinational), stall=0, no access, stay in IDLE, mdr_out unchanged.
- IDLE, aligned op:
  - stall=1 (combinational).
  - Latch addr, funct3, store_data and op type into internal registers.
  - Next state is ACCESS.
- ACCESS:
  - dmem_read or dmem_write=1, driven from the latched values. All dmem_* outputs stay stable until dmem_resp.
  - stall=1.
  - Inputs are ignored.
  - On dmem_resp: for a load, register the extracted value into mdr_out. Next state is DONE.
- DONE: dmem_read/write=0, stall=0 (the pipeline advances at this edge). Next state is IDLE.
- Store lanes:
  - SB: byte_enable=0001<<addr[1:0], wdata=store_data<<(8*addr[1:0]).
  - SH: byte_enable=0011<<addr[1:0], wdata shifted the same way.
  - SW: byte_enable=1111, wdata=store_data.
  - For loads, byte_enable=0000 and wdata=0.
- Load extraction: shift dmem_rdata right by 8*addr[1:0], then:
  - B: sign-extend bit 7.
  - BU: zero-extend byte.
  - H: sign-extend bit 15.
  - HU: zero-extend halfword.
  - W: the full word.
- mdr_out holds its value until the next load completes. Stores do not change it.

## Timing
- Reset (async, any state): state=IDLE and mdr_out=0. All outputs are 0, with stall and misaligned 0 unless a memory op is presented after reset deasserts.
  - An outstanding access is abandoned: dmem_read/write drop immediately.
  - A late dmem_resp after reset is ignored.
- Latency of a memory op is 2 + N cycles, where N ≥ 1 is the number of ACCESS cycles including the resp cycle. With resp in the first ACCESS cycle, stall is high for 2 cycles.
- Non-memory and misaligned ops add zero cycles.
- dmem_resp is ignored in IDLE and DONE.
- Back-to-back memory ops: DONE→IDLE→ACCESS, with one non-stalled DONE cycle between accesses. The new op asserts stall in its IDLE cycle.
- mdr_out is valid from the DONE cycle onward and is captured by the MEM/WB register at the DONE edge.

## Test plan
- LW addr=0x100, rdata=0xDEADBEEF, resp after 3 ACCESS cycles -> dmem_address=0x100, dmem_read high for 3 cycles, stall high for 4 cycles, mdr_out=0xDEADBEEF in DONE.
- LB addr=0x203 and LBU addr=0x203, rdata=0x80FF1122 -> mdr_out=0xFFFFFF80, then 0x00000080. LH addr=0x202 -> 0xFFFF80FF.
- SB addr=0x41, store_data=0x000000AB -> dmem_write=1, byte_enable=0010, wdata=0x0000AB00, address=0x40, mdr_out unchanged.
- LW addr=0x102 -> misaligned=1, stall=0, no dmem_read. Then SH addr=0x103 -> misaligned=1, no dmem_write.
- Assert rst mid-ACCESS, then a dmem_resp pulse after reset release -> dmem_read drops during reset, state stays IDLE, mdr_out=0.
- Non-memory op followed by two back-to-back LW ops, resp=1 in the first ACCESS cycle -> stall pattern 0,1,1,0,1,1,0 and two correct mdr_out values.

Source files
------------

// File: rtl/mem_stage_unit.sv
// MEM-stage data-memory access engine: issues load/store requests, stalls the
// pipeline until the memory responds, and produces the extended load value.
module mem_stage_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] mdr_out,
    output logic        stall,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [31:0] mdr_q, mdr_d;

    logic        mem_op;
    logic        req_misaligned;
    logic [4:0]  lane_shift;
    logic [31:0] rdata_shifted;
    logic [31:0] load_value;

    // funct3[1:0] selects width; 011/110/111 fall into the word case.
    always_comb begin
        mem_op = req_valid & (mem_read_req | mem_write_req);
        case (funct3[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = addr[0];
            default: req_misaligned = |addr[1:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        mdr_d        = mdr_q;
        stall        = 1'b0;
        misaligned   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (req_misaligned) begin
                        misaligned = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        addr_d       = addr;
                        store_data_d = store_data;
                        funct3_d     = funct3;
                        is_store_d   = mem_write_req;
                        state_d      = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_resp) begin
                    if (!is_store_q) begin
                        mdr_d = load_value;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side signals come only from the latched request so they stay
    // stable for the whole access regardless of the pipeline inputs.
    always_comb begin
        lane_shift       = {addr_q[1:0], 3'b000};
        rdata_shifted    = dmem_rdata >> lane_shift;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 32'd0;
        dmem_byte_enable = 4'b0000;
        dmem_wdata       = 32'd0;
        case (funct3_q)
            3'b000:  load_value = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_value = {24'd0, rdata_shifted[7:0]};
            3'b001:  load_value = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_value = {16'd0, rdata_shifted[15:0]};
            default: load_value = rdata_shifted;
        endcase
        if (state_q == ACCESS) begin
            dmem_read    = ~is_store_q;
            dmem_write   = is_store_q;
            dmem_address = {addr_q[31:2], 2'b00};
            if (is_store_q) begin
                dmem_wdata = store_data_q << lane_shift;
                case (funct3_q[1:0])
                    2'b00:   dmem_byte_enable = 4'b0001 << addr_q[1:0];
                    2'b01:   dmem_byte_enable = 4'b0011 << addr_q[1:0];
                    default: dmem_byte_enable = 4'b1111;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            store_data_q <= 32'd0;
            funct3_q     <= 3'd0;
            is_store_q   <= 1'b0;
            mdr_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            mdr_q        <= mdr_d;
        end
    end

    assign mdr_out = mdr_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed scenarios followed by random
// memory ops, all compared against an arithmetic model of load/store behaviour.
module tb_mem_stage_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mdr_out;
    logic        stall;
    logic        misaligned;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_mdr = 32'd0;

    mem_stage_unit dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .mem_read_req     (mem_read_req),
        .mem_write_req    (mem_write_req),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mdr_out          (mdr_out),
        .stall            (stall),
        .misaligned       (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access size in bytes implied by funct3; unlisted encodings act as words.
    function automatic int accessBytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rdata);
        longint unsigned w;
        longint unsigned v;
        w = longint'(rdata) / (longint'(1) << (8 * (a % 4)));
        case (f3)
            3'b000: begin
                v = w % 256;
                return (v >= 128) ? 32'(v + 64'hFFFF_FF00) : 32'(v);
            end
            3'b100: return 32'(w % 256);
            3'b001: begin
                v = w % 65536;
                return (v >= 32768) ? 32'(v + 64'hFFFF_0000) : 32'(v);
            end
            3'b101: return 32'(w % 65536);
            default: return 32'(w);
        endcase
    endfunction

    function automatic logic [3:0] modelEnable(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = accessBytes(f3);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) * (1 << (a % 4)));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] d, input logic [31:0] a);
        longint unsigned p;
        p = longint'(d) * (longint'(1) << (8 * (a % 4)));
        return 32'(p % (longint'(1) << 32));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd);
        req_valid     = v;
        mem_read_req  = rd;
        mem_write_req = wr;
        funct3        = f3;
        addr          = a;
        store_data    = sd;
    endtask

    // One complete op starting in IDLE; returns with the DUT back in IDLE.
    task automatic doOp(input string nm, input logic v, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                        input int nwait, input logic [31:0] rdata);
        logic is_op;
        logic is_mis;
        logic is_store;
        is_op    = v && (rd || wr);
        is_mis   = is_op && ((a % accessBytes(f3)) != 0);
        is_store = wr;
        applyStimulus(v, rd, wr, f3, a, sd);
        #1;
        checkOutput({nm, ":idle_stall"}, 32'(stall), 32'(is_op && !is_mis));
        checkOutput({nm, ":idle_mis"}, 32'(misaligned), 32'(is_mis));
        checkOutput({nm, ":idle_rw"}, {30'd0, dmem_read, dmem_write}, 32'd0);
        checkOutput({nm, ":idle_mdr"}, mdr_out, exp_mdr);
        nextCycle();
        if (!is_op || is_mis) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            return;
        end
        for (int k = 1; k <= nwait; k++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          3'($urandom), $urandom, $urandom);
            dmem_rdata = (k == nwait) ? rdata : $urandom;
            dmem_resp  = (k == nwait);
            #1;
            checkOutput({nm, ":acc_stall"}, 32'(stall), 32'd1);
            checkOutput({nm, ":acc_mis"}, 32'(misaligned), 32'd0);
            checkOutput({nm, ":acc_rw"}, {30'd0, dmem_read, dmem_write},
                        is_store ? 32'd1 : 32'd2);
            checkOutput({nm, ":acc_addr"}, dmem_address, a - (a % 4));
            checkOutput({nm, ":acc_be"}, 32'(dmem_byte_enable),
                        is_store ? 32'(modelEnable(f3, a)) : 32'd0);
            checkOutput({nm, ":acc_wdata"}, dmem_wdata, is_store ? modelWdata(sd, a) : 32'd0);
            nextCycle();
        end
        dmem_resp = 1'b0;
        if (!is_store) exp_mdr = modelLoad(f3, a, rdata);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        checkOutput({nm, ":done_stall"}, 32'(stall), 32'd0);
        checkOutput({nm, ":done_rw"}, {30'd0, dmem_read, dmem_write}, 32'd0);
        checkOutput({nm, ":done_mdr"}, mdr_out, exp_mdr);
        nextCycle();
    endtask

    initial begin
        logic [2:0] f3_pool [8];
        f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst        = 1'b1;
        dmem_rdata = 32'd0;
        dmem_resp  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_rw", {30'd0, dmem_read, dmem_write}, 32'd0);
        checkOutput("reset_mdr", mdr_out, 32'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        doOp("lw_100", 1, 1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        checkOutput("lw_100_hold", mdr_out, 32'hDEADBEEF);
        doOp("lb_203", 1, 1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80FF1122);
        checkOutput("lb_203_val", mdr_out, 32'hFFFFFF80);
        doOp("lbu_203", 1, 1, 0, 3'b100, 32'h203, 32'h0, 2, 32'h80FF1122);
        checkOutput("lbu_203_val", mdr_out, 32'h00000080);
        doOp("lh_202", 1, 1, 0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF1122);
        checkOutput("lh_202_val", mdr_out, 32'hFFFF80FF);
        doOp("sb_41", 1, 0, 1, 3'b000, 32'h41, 32'h000000AB, 2, 32'h12345678);
        checkOutput("sb_41_mdr", mdr_out, 32'hFFFF80FF);
        doOp("lw_102_mis", 1, 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
        doOp("sh_103_mis", 1, 0, 1, 3'b001, 32'h103, 32'h5555, 1, 32'h0);
        doOp("ld_st_both", 1, 1, 1, 3'b001, 32'h2A, 32'hCAFEF00D, 1, 32'h0);

        // Reset in the middle of an access, then a stray response afterwards.
        applyStimulus(1, 1, 0, 3'b010, 32'h300, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0);
        #1;
        checkOutput("rst_mid_pre_read", 32'(dmem_read), 32'd1);
        nextCycle();
        rst = 1'b1;
        #1;
        exp_mdr = 32'd0;
        checkOutput("rst_mid_read", 32'(dmem_read), 32'd0);
        checkOutput("rst_mid_stall", 32'(stall), 32'd0);
        checkOutput("rst_mid_mdr", mdr_out, 32'd0);
        nextCycle();
        rst = 1'b0;
        dmem_rdata = 32'h13572468;
        dmem_resp  = 1'b1;
        nextCycle();
        dmem_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("late_resp_rw", {30'd0, dmem_read, dmem_write}, 32'd0);
            checkOutput("late_resp_stall", 32'(stall), 32'd0);
            checkOutput("late_resp_mdr", mdr_out, 32'd0);
            nextCycle();
        end

        // Bubble then two back-to-back loads: stall 0,1,1,0,1,1,0.
        doOp("b2b_nop", 1, 0, 0, 3'b010, 32'h44, 32'h0, 1, 32'h0);
        doOp("b2b_lw0", 1, 1, 0, 3'b010, 32'h500, 32'h0, 1, 32'hA5A5F00F);
        doOp("b2b_lw1", 1, 1, 0, 3'b010, 32'h504, 32'h0, 1, 32'h0BADCAFE);
        checkOutput("b2b_final_mdr", mdr_out, 32'h0BADCAFE);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
            doOp("rand", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), f3_pool[$urandom_range(0, 7)], ra, $urandom,
                 $urandom_range(1, 4), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
